// File: rtl/fwd_source_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_source_pipe_pkg
// Description : Shared widths, pipeline-slot record and slot helpers for the
//               forwarding-source pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_source_pipe_pkg;

    localparam int             DW = 64;
    localparam int             AW = 5;
    localparam logic [AW-1:0]  ZR = 5'b11111;

    typedef struct packed {
        logic          v;
        logic          w;
        logic          ld;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } stage_slot_t;

    localparam stage_slot_t c_BUBBLE = '{v: 1'b0, w: 1'b0, ld: 1'b0, rd: ZR, data: '0};

    // XZR is architecturally discarded, so a write to it never counts.
    function automatic logic slot_writes(input stage_slot_t s);
        return s.v & s.w & (s.rd != ZR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_source_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_source_pipe_if
// Description : EX-stage, memory and forwarding-lookup bundle between the
//               core (master) and the forwarding-source pipeline (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_source_pipe_if import fwd_source_pipe_pkg::*; ();

    logic          ex_valid;
    logic          ex_reg_write;
    logic          ex_is_load;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] ex_result;
    logic          flush;
    logic          mem_stall;
    logic [DW-1:0] mem_load_data;
    logic [AW-1:0] id_rn;
    logic [AW-1:0] id_rm;

    logic          ex_ready;
    logic          load_use_stall;
    logic [AW-1:0] alu_rd_key;
    logic [DW-1:0] alu_result;
    logic [AW-1:0] mem_rd_key;
    logic [DW-1:0] mem_result;
    logic          wb_en;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    modport master (
        output ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_result,
               flush, mem_stall, mem_load_data, id_rn, id_rm,
        input  ex_ready, load_use_stall, alu_rd_key, alu_result,
               mem_rd_key, mem_result, wb_en, wb_rd, wb_data
    );

    modport slave (
        input  ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_result,
               flush, mem_stall, mem_load_data, id_rn, id_rm,
        output ex_ready, load_use_stall, alu_rd_key, alu_result,
               mem_rd_key, mem_result, wb_en, wb_rd, wb_data
    );

endinterface
`default_nettype wire

// File: rtl/fwd_source_pipe_stage_slot_reg.sv
`default_nettype none
// ============================================================================
// Module      : stage_slot_reg
// Description : One pipeline slot register; hold beats bubble beats load.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_slot_reg
    import fwd_source_pipe_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_hold,
    input  wire logic        i_bubble,
    input  wire stage_slot_t i_d,
    output stage_slot_t      o_q
);

    stage_slot_t r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= c_BUBBLE;
        end else if (!i_hold) begin
            if (i_bubble) begin
                r_q <= c_BUBBLE;
            end else begin
                r_q <= i_d;
            end
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/fwd_source_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fwd_source_pipe
// Description : EX/MEM and MEM/WB result registers publishing the two
//               forwarding sources, the writeback port and load-use stall.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_source_pipe
    import fwd_source_pipe_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    fwd_source_pipe_if.slave   bus
);

    stage_slot_t w_em_d;
    stage_slot_t w_em;
    stage_slot_t w_mw_d;
    stage_slot_t w_mw;
    logic        w_em_bubble;
    logic        w_em_writes;
    logic        w_mw_writes;
    logic        w_alu_fwd;

    assign w_em_bubble = !(bus.ex_valid && !bus.flush);

    always_comb begin
        w_em_d      = c_BUBBLE;
        w_em_d.v    = 1'b1;
        w_em_d.w    = bus.ex_reg_write;
        w_em_d.ld   = bus.ex_is_load;
        w_em_d.rd   = bus.ex_rd;
        w_em_d.data = bus.ex_result;
    end

    // The load flag is consumed here: MEM/WB always carries final data.
    always_comb begin
        w_mw_d      = c_BUBBLE;
        w_mw_d.v    = w_em.v;
        w_mw_d.w    = w_em.w;
        w_mw_d.rd   = w_em.rd;
        w_mw_d.data = w_em.ld ? bus.mem_load_data : w_em.data;
    end

    stage_slot_reg u_em_slot (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (bus.mem_stall),
        .i_bubble (w_em_bubble),
        .i_d      (w_em_d),
        .o_q      (w_em)
    );

    // A stalled MEM stage drains nothing downstream, so MEM/WB takes a bubble.
    stage_slot_reg u_mw_slot (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (1'b0),
        .i_bubble (bus.mem_stall),
        .i_d      (w_mw_d),
        .o_q      (w_mw)
    );

    assign w_em_writes = slot_writes(w_em);
    assign w_mw_writes = slot_writes(w_mw);
    assign w_alu_fwd   = w_em_writes && !w_em.ld;

    assign bus.ex_ready       = !bus.mem_stall;
    assign bus.load_use_stall = w_em_writes && w_em.ld &&
                                ((w_em.rd == bus.id_rn) || (w_em.rd == bus.id_rm));

    assign bus.alu_rd_key = w_alu_fwd ? w_em.rd   : ZR;
    assign bus.alu_result = w_alu_fwd ? w_em.data : '0;
    assign bus.mem_rd_key = w_mw_writes ? w_mw.rd   : ZR;
    assign bus.mem_result = w_mw_writes ? w_mw.data : '0;

    assign bus.wb_en   = w_mw_writes;
    assign bus.wb_rd   = w_mw.rd;
    assign bus.wb_data = w_mw.data;

endmodule
`default_nettype wire

// File: doc/fwd_source_pipe.md
Name: fwd_source_pipe

Overview:
- Producer side of the operand-forwarding interface. Holds the EX/MEM and MEM/WB result pipeline registers.
- Publishes the two (key, value) forwarding sources consumed by the forwarding unit: alu_rd_key/alu_result from EX/MEM and mem_rd_key/mem_result from MEM/WB.
- Drives the register-file write port and raises the load-use stall when forwarding cannot supply a value.
- Sits between the EX stage output and register-file writeback in the 64-bit pipelined core.

Parameters:
- DW, 64, datapath width.
- AW, 5, register index width.
- ZR, 5'b11111, X31/XZR index; also the "no source" key sentinel.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage presents an instruction this cycle
- ex_reg_write  in  1  instruction writes rd
- ex_is_load  in  1  instruction is a load; result comes from memory in MEM
- ex_rd  in  AW  destination register
- ex_result  in  DW  ALU result (load address is ignored here)
- flush  in  1  kill the instruction currently presented by EX
- mem_stall  in  1  data memory not ready; MEM stage must hold
- mem_load_data  in  DW  load data, valid while a load occupies EX/MEM and mem_stall=0
- id_rn  in  AW  consumer operand lookup (Rn)
- id_rm  in  AW  consumer operand lookup (Rm)
- ex_ready  out  1  EX may advance (= !mem_stall)
- load_use_stall  out  1  consumer must stall one cycle
- alu_rd_key  out  AW  EX/MEM forwarding key
- alu_result  out  DW  EX/MEM forwarding value
- mem_rd_key  out  AW  MEM/WB forwarding key
- mem_result  out  DW  MEM/WB forwarding value
- wb_en  out  1  register-file write enable
- wb_rd  out  AW  register-file write index
- wb_data  out  DW  register-file write data

Behaviour:
- State registers:
  - EX/MEM slot: em_v, em_w, em_ld, em_rd, em_res.
  - MEM/WB slot: mw_v, mw_w, mw_rd, mw_data.
- Reset (synchronous, highest priority): all valid bits and write flags are 0; rd fields = ZR; data = 0.
  - Outputs after reset: keys = ZR, results = 0, wb_en = 0, wb_rd = ZR, wb_data = 0, load_use_stall = 0, ex_ready = !mem_stall.
- Rising edge with mem_stall=0:
  - EX/MEM slot loads the ex_* inputs when ex_valid & !flush. Otherwise it loads a bubble (v=0, rd=ZR, data=0).
  - MEM/WB slot loads the EX/MEM slot. mw_data = em_ld ? mem_load_data : em_res.
- Rising edge with mem_stall=1:
  - EX/MEM slot holds; flush is ignored for the held slot.
  - MEM/WB slot loads a bubble.
  - EX inputs are not captured.
- Write normalisation: a slot "writes" only when v & w & rd != ZR. A write to XZR is discarded and publishes key ZR.
- alu_rd_key:
  - = em_rd when EX/MEM writes and !em_ld, else ZR.
  - alu_result = em_res under the same condition, else 0.
  - A load in EX/MEM is never forwarded because its data is not ready.
- mem_rd_key / mem_result = mw_rd / mw_data when MEM/WB writes, else ZR / 0.
- wb_en = MEM/WB writes; wb_rd = mw_rd; wb_data = mw_data.
  - Writeback occurs in the same cycle the value is published as mem_result.
- load_use_stall (combinational):
  - = EX/MEM writes & em_ld & (em_rd == id_rn | em_rd == id_rm).
  - Lookups equal to ZR never stall.
  - Asserted for exactly one cycle per load if mem_stall=0. While mem_stall=1 it persists as long as the load is held.
- Latency:
  - Result visible on alu_* 1 cycle after EX capture.
  - Result visible on mem_*/wb_* 2 cycles after EX capture.
  - Load data visible on mem_* 1 cycle after a non-stalled MEM cycle.
- Simultaneous events:
  - reset > mem_stall > flush > ex_valid.
  - flush with ex_valid=0 inserts a bubble, same as no instruction.
- Consumer priority (alu_* newer than mem_*) is the forwarding unit's responsibility. This block may publish the same rd on both keys.

Decomposition:
- Shared package (pipeline package):
  - AW, DW, ZR constants.
  - Packed struct stage_slot_t {v, w, ld, rd, data}, used for both slots.
  - Function slot_writes(stage_slot_t).
- One natural sub-module: stage_slot_reg, a slot register with hold/bubble/load controls, instantiated twice.

Test Plan:
- Reset mid-stream: ADD X3 in EX/MEM, assert reset 1 cycle -> next cycle alu_rd_key=31, mem_rd_key=31, wb_en=0, all data 0.
- ALU chain: EX X3=0x10, then X4=0x20 -> cycle+1 alu=(3,0x10); cycle+2 alu=(4,0x20), mem=(3,0x10), wb_en=1, wb_rd=3.
- Load-use: LDUR X5 in EX/MEM, id_rn=5, mem_load_data=0xDEAD -> load_use_stall=1, alu_rd_key=31; next cycle mem=(5,0xDEAD), stall=0.
- XZR write: EX rd=31, reg_write=1, result=0x99 -> alu_rd_key=31, alu_result=0, later wb_en=0; id_rm=31 never stalls.
- mem_stall 2 cycles with LDUR X7 in EX/MEM and flush=1 -> slot held, ex_ready=0, mem key=31, load_use_stall held for id_rn=7; on release mem=(7,data).
- Flush: ex_valid=1, flush=1, rd=8 -> EX/MEM bubble, alu_rd_key=31, no writeback two cycles later.
